// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops RATIO narrow words from a show-ahead FIFO into one wide
// valid/ready beat; flush emits a partial beat. Define FIFO_PACK_MSB_FIRST_EN for MSB-first lanes.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                          rd_clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_rd_en,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]              out_keep,
  output logic                          out_last,
  output logic                          busy
);

  localparam int CW = $clog2(RATIO);
  localparam int BW = DATA_WIDTH * RATIO;
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  localparam logic [0:0] ST_ACC   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [BW-1:0]   acc_data_q, acc_data_d;
  logic            out_valid_q, out_valid_d;
  logic [BW-1:0]   out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic            out_last_q, out_last_d;

  logic            slot_free;
  logic            pop;
  logic [CW-1:0]   lane;
  logic [BW-1:0]   acc_ins;
  logic [RATIO-1:0] part_keep;

  assign slot_free = !out_valid_q || out_ready;
  assign pop = (state_q == ST_ACC) && !fifo_empty && ((acc_cnt_q != LAST_CNT) || slot_free);
  // Gate with rst_n so nothing is popped while the block is held in reset.
  assign fifo_rd_en = rst_n && pop;

`ifdef FIFO_PACK_MSB_FIRST_EN
  assign lane = LAST_CNT - acc_cnt_q;
  always_comb begin
    part_keep = '0;
    for (int i = 0; i < RATIO; i++) part_keep[i] = (CW'(RATIO - 1 - i) < acc_cnt_q);
  end
`else
  assign lane = acc_cnt_q;
  always_comb begin
    part_keep = '0;
    for (int i = 0; i < RATIO; i++) part_keep[i] = (CW'(i) < acc_cnt_q);
  end
`endif

  always_comb begin
    acc_ins = acc_data_q;
    acc_ins[int'(lane) * DATA_WIDTH +: DATA_WIDTH] = fifo_data;
  end

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    acc_data_d  = acc_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (state_q == ST_ACC) begin
      if (pop) begin
        if (acc_cnt_q == LAST_CNT) begin
          // A flush coinciding with the completing pop just tags the full beat.
          out_data_d  = acc_ins;
          out_keep_d  = '1;
          out_valid_d = 1'b1;
          out_last_d  = flush;
          acc_cnt_d   = '0;
          acc_data_d  = '0;
        end else begin
          acc_data_d = acc_ins;
          acc_cnt_d  = acc_cnt_q + CW'(1);
          if (flush) state_d = ST_FLUSH;
        end
      end else if (flush) begin
        state_d = ST_FLUSH;
      end
    end else begin
      if (acc_cnt_q == '0) begin
        state_d = ST_ACC;
      end else if (slot_free) begin
        out_data_d  = acc_data_q;
        out_keep_d  = part_keep;
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        acc_cnt_d   = '0;
        acc_data_d  = '0;
        state_d     = ST_ACC;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_cnt_q   <= '0;
      acc_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_data_q  <= acc_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign busy      = (acc_cnt_q != '0) || out_valid_q || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed self-checking bench for fifo_rd_packer (DATA_WIDTH=8, RATIO=4, LSB-first build),
// with a small show-ahead FIFO model built on a queue.
module tb_fifo_rd_packer;

  logic        rd_clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        busy;

  logic [7:0]  fq[$];
  int          compared;
  int          mismatched;

  fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic updateFifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic applyStimulus(input logic rdy, input logic fl);
    out_ready = rdy;
    flush     = fl;
    updateFifo();
    #1;
  endtask

  // One clock: the model pops its head if the DUT asked for it at this edge.
  task automatic tick();
    logic popNow;
    popNow = fifo_rd_en;
    @(posedge rd_clk);
    if (popNow && fq.size() > 0) fq.delete(0);
    #1;
    updateFifo();
    #1;
  endtask

  task automatic pushWords(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    flush      = 1'b0;
    fq.delete();

    // 1: reset held with a non-empty FIFO
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    applyStimulus(1'b1, 1'b0);
    tick(); tick();
    checkOutput("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_keep", 64'(out_keep), 64'd0);
    checkOutput("rst_last", 64'(out_last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_data", 64'(out_data), 64'd0);

    // 2: four back-to-back words, downstream ready
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_rd_en_%0d", i), 64'(fifo_rd_en), 64'd1);
      checkOutput($sformatf("t2_novalid_%0d", i), 64'(out_valid), 64'd0);
      tick();
    end
    checkOutput("t2_valid", 64'(out_valid), 64'd1);
    checkOutput("t2_data", 64'(out_data), 64'h44332211);
    checkOutput("t2_keep", 64'(out_keep), 64'hF);
    checkOutput("t2_last", 64'(out_last), 64'd0);
    checkOutput("t2_rd_en_empty", 64'(fifo_rd_en), 64'd0);
    tick();
    checkOutput("t2_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("t2_busy_idle", 64'(busy), 64'd0);

    // 3: backpressure, words 0x01..0x08
    pushWords(8'h01, 8);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t3_valid", 64'(out_valid), 64'd1);
    checkOutput("t3_data", 64'(out_data), 64'h04030201);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t3_rd_en_%0d", i), 64'(fifo_rd_en), 64'd1);
      tick();
      checkOutput($sformatf("t3_hold_data_%0d", i), 64'(out_data), 64'h04030201);
      checkOutput($sformatf("t3_hold_valid_%0d", i), 64'(out_valid), 64'd1);
    end
    checkOutput("t3_stall_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("t3_fifo_left", 64'(fq.size()), 64'd1);
    checkOutput("t3_busy", 64'(busy), 64'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_resume_rd_en", 64'(fifo_rd_en), 64'd1);
    tick();
    checkOutput("t3_beat2_valid", 64'(out_valid), 64'd1);
    checkOutput("t3_beat2_data", 64'(out_data), 64'h08070605);
    checkOutput("t3_beat2_keep", 64'(out_keep), 64'hF);
    checkOutput("t3_fifo_drained", 64'(fq.size()), 64'd0);
    tick();
    checkOutput("t3_valid_drop", 64'(out_valid), 64'd0);

    // 4: partial flush after two words
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    applyStimulus(1'b1, 1'b0);
    tick(); tick();
    applyStimulus(1'b1, 1'b1);
    tick();
    fq.push_back(8'hCC);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_flush_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("t4_flush_busy", 64'(busy), 64'd1);
    tick();
    checkOutput("t4_valid", 64'(out_valid), 64'd1);
    checkOutput("t4_data", 64'(out_data), 64'h0000BBAA);
    checkOutput("t4_keep", 64'(out_keep), 64'h3);
    checkOutput("t4_last", 64'(out_last), 64'd1);
    checkOutput("t4_resume_rd_en", 64'(fifo_rd_en), 64'd1);
    tick();
    checkOutput("t4_valid_drop", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("t4_single_data", 64'(out_data), 64'h000000CC);
    checkOutput("t4_single_keep", 64'(out_keep), 64'h1);
    checkOutput("t4_single_last", 64'(out_last), 64'd1);
    tick();

    // 4b: flush coinciding with the pop that completes a beat
    pushWords(8'h21, 4);
    applyStimulus(1'b1, 1'b0);
    tick(); tick(); tick();
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4b_data", 64'(out_data), 64'h24232221);
    checkOutput("t4b_keep", 64'(out_keep), 64'hF);
    checkOutput("t4b_last", 64'(out_last), 64'd1);
    tick();
    checkOutput("t4b_busy_acc", 64'(busy), 64'd0);

    // 5: flush with nothing accumulated
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_no_beat", 64'(out_valid), 64'd0);
    tick();
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_no_beat2", 64'(out_valid), 64'd0);

    // 6: asynchronous reset with a held beat and three accumulated words
    pushWords(8'h01, 4);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    pushWords(8'h05, 3);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    fq.push_back(8'h08);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t6_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_async_busy", 64'(busy), 64'd0);
    checkOutput("t6_async_rd_en", 64'(fifo_rd_en), 64'd0);
    tick();
    fq.delete();
    pushWords(8'h01, 4);
    applyStimulus(1'b1, 1'b0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t6_valid", 64'(out_valid), 64'd1);
    checkOutput("t6_data", 64'(out_data), 64'h04030201);
    checkOutput("t6_keep", 64'(out_keep), 64'hF);
    checkOutput("t6_last", 64'(out_last), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
